// File: rtl/fetch_issue.sv
// rtl/fetch_issue.sv - instruction fetch/issue sequencer for the vector core front end
module fetch_issue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_in,
  input  logic               jump_taken,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [4:0]         opcode,
  output logic [INSTR_W-1:0] instr,
  output logic               issue_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FETCH   = 3'd2,
    ISSUE   = 3'd3,
    MEM     = 3'd4,
    RESOLVE = 3'd5,
    HALTED  = 3'd6
  } state_t;

  localparam logic [4:0] OP_CMPJ = 5'd6;
  localparam logic [4:0] OP_LDV  = 5'd12;
  localparam logic [4:0] OP_STV  = 5'd13;
  localparam logic [4:0] OP_HALT = 5'd31;

  localparam logic [3:0]        MEM_LAT_C = 4'(MEM_LAT);
  localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [3:0]        mem_cnt;
  logic [4:0]        fetched_op;
  logic [4:0]        held_op;

  assign fetched_op = imem_rdata[INSTR_W-1 -: 5];
  // Control flow follows the raw opcode field, since halt and undefined
  // opcodes are presented to the decoder as 0.
  assign held_op    = instr[INSTR_W-1 -: 5];

  assign issue_valid = (state == ISSUE);
  assign busy        = (state != IDLE) && (state != HALTED);

  function automatic logic op_defined(input logic [4:0] op);
    case (op)
      5'd0, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9,
      5'd10, 5'd12, 5'd13, 5'd31: op_defined = 1'b1;
      default:                    op_defined = 1'b0;
    endcase
  endfunction

  // Next state and next PC; every PC change coincides with entering REQ.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
          pc_nxt    = '0;
        end
      end
      REQ:   state_nxt = FETCH;
      FETCH: state_nxt = ISSUE;
      ISSUE: begin
        if (!stall_in) begin
          case (held_op)
            OP_LDV, OP_STV: state_nxt = MEM;
            OP_CMPJ:        state_nxt = RESOLVE;
            OP_HALT:        state_nxt = HALTED;
            default: begin
              state_nxt = REQ;
              pc_nxt    = pc + PC_ONE;
            end
          endcase
        end
      end
      MEM: begin
        if (mem_cnt == 4'd1) begin
          state_nxt = REQ;
          pc_nxt    = pc + PC_ONE;
        end
      end
      RESOLVE: begin
        state_nxt = REQ;
        pc_nxt    = jump_taken ? jump_target : pc + PC_ONE;
      end
      HALTED: begin
        if (start) begin
          state_nxt = REQ;
          pc_nxt    = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // PC and fetch address move together so imem_addr equals pc during REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      imem_addr <= '0;
    end else begin
      pc        <= pc_nxt;
      imem_addr <= pc_nxt;
    end
  end

  // Capture the fetched word; undefined and halt opcodes reach the decoder as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr   <= '0;
      opcode  <= '0;
      illegal <= 1'b0;
    end else if (state == FETCH) begin
      instr   <= imem_rdata;
      opcode  <= (op_defined(fetched_op) && fetched_op != OP_HALT) ? fetched_op : 5'd0;
      illegal <= !op_defined(fetched_op);
    end else begin
      illegal <= 1'b0;
    end
  end

  // Memory-occupancy countdown for ldv/stv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt <= '0;
    end else if (state == ISSUE && state_nxt == MEM) begin
      mem_cnt <= MEM_LAT_C;
    end else if (state == MEM) begin
      mem_cnt <= mem_cnt - 4'd1;
    end
  end

  // Halted flag mirrors residency in HALTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else     halted <= (state_nxt == HALTED);
  end

endmodule
